// File: rtl/ram_pipelined.sv
// Single-port synchronous RAM with a configurable read pipeline (1..3 cycles)
// and an optional post-reset clear sequence that fills every word.
module ram_pipelined #(
    parameter int unsigned           ADDR_WIDTH     = 6,
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           READ_LATENCY   = 1,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   counter;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    rd_req;

    logic                    stage_valid;
    logic [DATA_WIDTH-1:0]   stage_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? CLEAR : READY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (counter == '1) begin
                    state_next = READY;
                end
            end
            READY: state_next = READY;
            default: state_next = READY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else if (state == CLEAR) begin
            counter <= counter + 1'b1;
        end
    end

    // The clear sequence borrows the single write port; user requests are
    // locked out entirely while it runs, and while reset is held.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = data_in;
        rd_req    = 1'b0;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_addr  = counter;
                mem_wdata = CLEAR_VALUE;
            end else if (write_enable) begin
                mem_we = 1'b1;
            end else if (read_enable) begin
                rd_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Latency 1 feeds the output register straight from the array; longer
    // latencies insert READ_LATENCY-1 tagged stages ahead of it.
    generate
        if (READ_LATENCY <= 1) begin : g_direct
            always_comb begin
                stage_valid = rd_req;
                stage_data  = mem[address];
            end
        end else begin : g_pipe
            localparam int unsigned STAGES = READ_LATENCY - 1;
            logic [STAGES-1:0]     pipe_valid;
            logic [DATA_WIDTH-1:0] pipe_data [STAGES];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pipe_valid <= '0;
                    for (int unsigned i = 0; i < STAGES; i++) begin
                        pipe_data[i] <= '0;
                    end
                end else begin
                    pipe_valid[0] <= rd_req;
                    if (rd_req) begin
                        pipe_data[0] <= mem[address];
                    end
                    for (int unsigned i = 1; i < STAGES; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                        pipe_data[i]  <= pipe_data[i-1];
                    end
                end
            end

            always_comb begin
                stage_valid = pipe_valid[STAGES-1];
                stage_data  = pipe_data[STAGES-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= stage_valid;
            if (stage_valid) begin
                data_out <= stage_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_pipelined.sv
// Scoreboard bench: one stimulus stream drives a latency-1 and a latency-3
// instance; a reference memory model predicts every read and its arrival cycle.
module tb_ram_pipelined;

    typedef struct {
        logic [7:0]  data;
        int unsigned due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] address = '0;
    logic [7:0] data_in = '0;
    logic       write_enable = 1'b0;
    logic       read_enable = 1'b0;

    logic [7:0] dout [2];
    logic       dv   [2];
    logic       bsy  [2];

    int          checks = 0;
    int          errors = 0;
    int unsigned cycle = 0;
    int          lat [2] = '{1, 3};

    exp_t        q [2][$];
    logic [7:0]  last_out [2];
    logic [7:0]  model_mem [64];
    int          busy_left = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    ram_pipelined #(.READ_LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .write_enable(write_enable), .read_enable(read_enable),
        .data_out(dout[0]), .data_valid(dv[0]), .busy(bsy[0])
    );

    ram_pipelined #(.READ_LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .write_enable(write_enable), .read_enable(read_enable),
        .data_out(dout[1]), .data_valid(dv[1]), .busy(bsy[1])
    );

    // Monitor: pops the scoreboard whenever data_valid is seen.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                checks++;
                if (dv[k] !== 1'b0 || dout[k] !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_outputs L%0d: valid=%b data=%h required valid=0 data=00",
                             lat[k], dv[k], dout[k]);
                end
            end else if (dv[k] === 1'b1) begin
                checks++;
                if (q[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid L%0d cycle %0d: data=%h required no valid",
                             lat[k], cycle, dout[k]);
                end else begin
                    e = q[k].pop_front();
                    if (dout[k] !== e.data || cycle != e.due) begin
                        errors++;
                        $display("FAIL read_data L%0d: got %h at cycle %0d required %h at cycle %0d",
                                 lat[k], dout[k], cycle, e.data, e.due);
                    end
                    last_out[k] = e.data;
                end
            end else begin
                checks++;
                if (dv[k] !== 1'b0 || dout[k] !== last_out[k]) begin
                    errors++;
                    $display("FAIL data_out_hold L%0d cycle %0d: valid=%b data=%h required valid=0 data=%h",
                             lat[k], cycle, dv[k], dout[k], last_out[k]);
                end
                if (q[k].size() > 0 && q[k][0].due < cycle) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_valid L%0d: no valid at cycle %0d required data %h",
                             lat[k], q[k][0].due, q[k][0].data);
                    void'(q[k].pop_front());
                end
            end
        end
    end

    // Called right after a falling edge; returns at the next falling edge.
    task automatic step(input logic we, input logic re, input logic [5:0] a, input logic [7:0] d);
        write_enable = we;
        read_enable  = re;
        address      = a;
        data_in      = d;
        if (busy_left == 0) begin
            if (we) begin
                model_mem[a] = d;
            end else if (re) begin
                for (int k = 0; k < 2; k++) begin
                    q[k].push_back('{data: model_mem[a], due: cycle + lat[k]});
                end
            end
        end
        @(posedge clk);
        if (busy_left > 0) busy_left--;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bsy[k] !== (busy_left > 0)) begin
                errors++;
                $display("FAIL busy L%0d cycle %0d: got %b required %b",
                         lat[k], cycle, bsy[k], (busy_left > 0));
            end
        end
    endtask

    task automatic reset_dut();
        #1;
        reset        = 1'b1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            last_out[k] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        busy_left = 64;
        for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bsy[k] !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_release L%0d: got %b required 1", lat[k], bsy[k]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] a;
        int op;
        for (int k = 0; k < 2; k++) last_out[k] = 8'h00;
        reset_dut();

        // Clear runs 64 cycles; a write during it must be dropped.
        step(1'b1, 1'b0, 6'd1, 8'hFF);
        idle(63);
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 6'(i), 8'h00);
        idle(4);

        step(1'b1, 1'b0, 6'd3, 8'hA5);
        step(1'b0, 1'b1, 6'd3, 8'h00);
        idle(4);

        step(1'b1, 1'b1, 6'd5, 8'h3C);
        idle(4);
        step(1'b0, 1'b1, 6'd5, 8'h00);
        idle(4);

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'(i), 8'(i + 16));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'(i), 8'h00);
        idle(4);

        for (int i = 0; i < 300; i++) begin
            a  = 6'($urandom_range(0, 15));
            op = int'($urandom_range(0, 3));
            step(op[0], op[1], a, 8'($urandom));
        end
        idle(4);

        // Reset mid-clear at counter 20, then with two reads in flight.
        reset_dut();
        idle(20);
        reset_dut();
        idle(64);
        step(1'b1, 1'b0, 6'd9, 8'h5A);
        step(1'b0, 1'b1, 6'd9, 8'h00);
        step(1'b0, 1'b1, 6'd1, 8'h00);
        reset_dut();
        idle(64);
        step(1'b0, 1'b1, 6'd9, 8'h00);
        step(1'b0, 1'b1, 6'd1, 8'h00);
        idle(6);

        for (int k = 0; k < 2; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                errors++;
                $display("FAIL drain L%0d: %0d reads outstanding required 0", lat[k], q[k].size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
